// File: rtl/outarb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | outarb_pkg : flit type codes, arbiter state encoding and default sizes
// | Rev 1.0
// +----------------------------------------------------------------------------
package outarb_pkg;

  localparam int DEF_N_IN   = 4;
  localparam int DEF_FLIT_W = 10;

  localparam logic [1:0] HEAD   = 2'b10;
  localparam logic [1:0] BODY   = 2'b00;
  localparam logic [1:0] TAIL   = 2'b01;
  localparam logic [1:0] SINGLE = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // True for the flit that closes a packet and releases the output.
  function automatic logic is_last(input logic [1:0] ftype);
    case (ftype)
      HEAD, BODY:   is_last = 1'b0;
      TAIL, SINGLE: is_last = 1'b1;
      default:      is_last = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/outarb_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | rr_pick : one-hot round-robin winner, first request at or above ptr
// | Rev 1.0
// +----------------------------------------------------------------------------
module rr_pick
  import outarb_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int PTR_W = 2
) (
  input  logic [N_IN-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_IN-1:0]  win
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_IN; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_IN);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/outarb.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | outarb : per-output wormhole arbiter, round-robin on headers, registered out
// | Rev 1.0
// +----------------------------------------------------------------------------
module outarb
  import outarb_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int FLIT_W = DEF_FLIT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          req,
  input  logic [N_IN-1:0]          in_valid,
  input  logic [N_IN*FLIT_W-1:0]   in_flit,
  output logic [N_IN-1:0]          ack,
  output logic [N_IN-1:0]          grant,
  output logic [FLIT_W-1:0]        pkto,
  output logic                     pkto_valid,
  input  logic                     pkto_ready
);

  localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  state_e              state_q;
  logic [N_IN-1:0]     grant_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    ptr_d;
  logic [FLIT_W-1:0]   pkto_q;
  logic                pkto_valid_q;

  logic [N_IN-1:0]     win;
  logic [FLIT_W-1:0]   sel_flit;
  logic                slot_free;
  logic                ack_any;

  rr_pick #(
    .N_IN  (N_IN),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .win (win)
  );

  // Owner's flit and the pointer position just past the owner.
  always_comb begin
    sel_flit = '0;
    ptr_d    = ptr_q;
    for (int i = 0; i < N_IN; i++) begin
      if (grant_q[i]) begin
        sel_flit = in_flit[i*FLIT_W +: FLIT_W];
        ptr_d    = PTR_W'((i + 1) % N_IN);
      end
    end
  end

  assign slot_free = !pkto_valid_q || pkto_ready;
  assign ack       = (state_q == BUSY && slot_free) ? (grant_q & in_valid) : '0;
  assign ack_any   = |ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ptr_q        <= '0;
      pkto_q       <= '0;
      pkto_valid_q <= 1'b0;
    end else begin
      if (ack_any) begin
        pkto_q       <= sel_flit;
        pkto_valid_q <= 1'b1;
      end else if (pkto_ready) begin
        pkto_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q <= win;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (ack_any && is_last(sel_flit[FLIT_W-1 -: 2])) begin
            grant_q <= '0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant      = grant_q;
  assign pkto       = pkto_q;
  assign pkto_valid = pkto_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_outarb.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_outarb : scenario tasks with a flit scoreboard for outarb
// | Rev 1.0
// +----------------------------------------------------------------------------
module tb_outarb;
  import outarb_pkg::*;

  localparam int N  = 4;
  localparam int FW = 10;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0]      in_valid;
  logic [N*FW-1:0]   in_flit;
  logic [N-1:0]      ack;
  logic [N-1:0]      grant;
  logic [FW-1:0]     pkto;
  logic              pkto_valid;
  logic              pkto_ready;

  outarb #(.N_IN(N), .FLIT_W(FW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .in_valid   (in_valid),
    .in_flit    (in_flit),
    .ack        (ack),
    .grant      (grant),
    .pkto       (pkto),
    .pkto_valid (pkto_valid),
    .pkto_ready (pkto_ready)
  );

  // Per-input flit sources and the expected output stream.
  logic [FW-1:0] mem [N][32];
  logic [4:0]    rd  [N];
  logic [4:0]    wr  [N];
  logic [N-1:0]  gap;
  logic [N-1:0]  acked;
  logic [FW-1:0] exp_q [$];
  int            checks;
  int            failures;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic [FW-1:0] f;
      f = (rd[i] != wr[i]) ? mem[i][rd[i]] : '0;
      in_valid[i] = (rd[i] != wr[i]) && !gap[i];
      in_flit[i*FW +: FW] = f;
      req[i] = in_valid[i] && f[FW-1];
    end
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  task automatic load(input int i, input logic [1:0] t, input logic [7:0] p, input bit expect_out);
    mem[i][wr[i]] = {t, p};
    wr[i] = wr[i] + 5'd1;
    if (expect_out) exp_q.push_back({t, p});
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      rd[i] = '0;
      wr[i] = '0;
    end
    gap = '0;
    exp_q.delete();
  endtask

  // One clock: score any accepted output flit, then pop acked sources.
  task automatic step();
    logic [FW-1:0] e;
    settle();
    acked = ack;
    if (pkto_valid && pkto_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra: got flit %h, none expected", pkto);
      end else begin
        e = exp_q.pop_front();
        if (pkto !== e) begin
          failures++;
          $display("FAIL sb_flit: got %h, expected %h", pkto, e);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acked[i] && rd[i] != wr[i]) rd[i] = rd[i] + 5'd1;
    settle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pkto_ready = 1'b1;
    flush();
    step();
    step();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rst_grant: got %b, expected 0000", grant); end
    checks++; if (pkto_valid !== 1'b0) begin failures++; $display("FAIL rst_pkto_valid: got %b, expected 0", pkto_valid); end
    checks++; if (pkto !== 10'h000) begin failures++; $display("FAIL rst_pkto: got %h, expected 000", pkto); end
    rst = 1'b0;
    load(0, SINGLE, 8'h5A, 1);
    settle();
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rst_ack_after: got %b, expected 0000", ack); end
    step();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rst_first_grant: got %b, expected 0001", grant); end
    repeat (3) step();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rst_leftover: %0d flits missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_single();
    flush();
    load(0, HEAD,   8'hA0, 1);
    load(0, BODY,   8'hA1, 1);
    load(0, TAIL,   8'hA2, 1);
    settle();
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL single_idle_ack: got %b, expected 0000", ack); end
    step();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b, expected 0001", grant); end
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL single_ack_head: got %b, expected 0001", ack); end
    step();
    checks++; if (pkto_valid !== 1'b1 || pkto !== {HEAD, 8'hA0}) begin failures++; $display("FAIL single_pkto_head: got v=%b %h, expected v=1 %h", pkto_valid, pkto, {HEAD, 8'hA0}); end
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL single_ack_body: got %b, expected 0001", ack); end
    step();
    step();
    checks++; if (pkto !== {TAIL, 8'hA2}) begin failures++; $display("FAIL single_pkto_tail: got %h, expected %h", pkto, {TAIL, 8'hA2}); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL single_grant_clear: got %b, expected 0000", grant); end
    step();
    checks++; if (pkto_valid !== 1'b0) begin failures++; $display("FAIL single_valid_clear: got %b, expected 0", pkto_valid); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_leftover: %0d flits missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_contention();
    logic [N-1:0] eg;
    rst = 1'b1;
    flush();
    step();
    rst = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        load(i, SINGLE, 8'(16 * (r + 1) + i), 1);
    settle();
    for (int k = 0; k < 2 * N; k++) begin
      step();
      eg = 4'b0001 << (k % N);
      checks++; if (grant !== eg) begin failures++; $display("FAIL cont_grant_%0d: got %b, expected %b", k, grant, eg); end
      step();
    end
    repeat (3) step();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL cont_leftover: %0d flits missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    flush();
    load(1, HEAD, 8'h30, 1);
    load(1, BODY, 8'h31, 1);
    load(1, BODY, 8'h32, 1);
    load(1, TAIL, 8'h33, 1);
    settle();
    step();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL bp_grant: got %b, expected 0010", grant); end
    step();
    pkto_ready = 1'b0;
    settle();
    for (int c = 0; c < 3; c++) begin
      checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL bp_ack_stall_%0d: got %b, expected 0000", c, ack); end
      checks++; if (pkto_valid !== 1'b1 || pkto !== {HEAD, 8'h30}) begin failures++; $display("FAIL bp_pkto_stall_%0d: got v=%b %h, expected v=1 %h", c, pkto_valid, pkto, {HEAD, 8'h30}); end
      step();
    end
    pkto_ready = 1'b1;
    settle();
    checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL bp_ack_resume: got %b, expected 0010", ack); end
    repeat (5) step();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL bp_grant_end: got %b, expected 0000", grant); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_leftover: %0d flits missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_ignored_req();
    flush();
    load(1, HEAD, 8'h40, 1);
    load(1, BODY, 8'h41, 1);
    load(1, TAIL, 8'h42, 1);
    settle();
    step();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL ign_grant: got %b, expected 0010", grant); end
    step();
    load(2, SINGLE, 8'h43, 1);
    settle();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL ign_hold_a: got %b, expected 0010", grant); end
    step();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL ign_hold_b: got %b, expected 0010", grant); end
    step();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL ign_release: got %b, expected 0000", grant); end
    step();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL ign_next_winner: got %b, expected 0100", grant); end
    repeat (4) step();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ign_leftover: %0d flits missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_gaps();
    flush();
    load(3, HEAD, 8'h50, 1);
    load(3, BODY, 8'h51, 1);
    load(3, TAIL, 8'h52, 1);
    settle();
    step();
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL gap_grant: got %b, expected 1000", grant); end
    step();
    gap[3] = 1'b1;
    settle();
    for (int c = 0; c < 2; c++) begin
      checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL gap_ack_%0d: got %b, expected 0000", c, ack); end
      checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL gap_grant_hold_%0d: got %b, expected 1000", c, grant); end
      step();
    end
    gap[3] = 1'b0;
    settle();
    checks++; if (ack !== 4'b1000) begin failures++; $display("FAIL gap_ack_resume: got %b, expected 1000", ack); end
    repeat (5) step();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL gap_leftover: %0d flits missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    flush();
    load(1, SINGLE, 8'h60, 1);
    settle();
    step();
    step();
    load(2, HEAD, 8'h61, 1);
    load(2, BODY, 8'h62, 1);
    load(2, TAIL, 8'h63, 0);
    settle();
    step();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL rmid_grant: got %b, expected 0100", grant); end
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rmid_grant_clear: got %b, expected 0000", grant); end
    checks++; if (pkto_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid_clear: got %b, expected 0", pkto_valid); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rmid_ack: got %b, expected 0000", ack); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rmid_leftover: %0d flits missing, expected 0", exp_q.size()); end
    flush();
    load(0, SINGLE, 8'h71, 1);
    load(3, SINGLE, 8'h70, 1);
    settle();
    step();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rmid_ptr_reset: got %b, expected 0001", grant); end
    repeat (5) step();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rmid_tail_leftover: %0d flits missing, expected 0", exp_q.size()); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    pkto_ready = 1'b1;
    req        = '0;
    in_valid   = '0;
    in_flit    = '0;
    gap        = '0;
    acked      = '0;
    flush();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_ignored_req();
    test_gaps();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
